// File: rtl/rv_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rv_mem_pkg
// Description : RV32I load/store width codes, byte-enable patterns, the
//               MEM-stage FSM encoding and the access legality check.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_mem_pkg;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    localparam logic [3:0] c_BE_BYTE = 4'b0001;
    localparam logic [3:0] c_BE_HALF = 4'b0011;
    localparam logic [3:0] c_BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mau_state_t;

    // funct3[1:0] encodes the access size for both loads and stores.
    function automatic logic access_ok(input logic       is_load,
                                       input logic [2:0] f3,
                                       input logic [1:0] addr_lo);
        logic code_ok;
        logic align_ok;
        if (is_load)
            code_ok = f3 inside {c_F3_B, c_F3_H, c_F3_W, c_F3_BU, c_F3_HU};
        else
            code_ok = f3 inside {c_F3_B, c_F3_H, c_F3_W};
        case (f3[1:0])
            2'b01:   align_ok = ~addr_lo[0];
            2'b10:   align_ok = (addr_lo == 2'b00);
            default: align_ok = 1'b1;
        endcase
        return code_ok & align_ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Store lane replication / byte enables and load byte/half
//               extraction with sign or zero extension. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import rv_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      st_size,
    input  logic [1:0]      st_addr_lo,
    input  logic [XLEN-1:0] st_data,
    output logic [XLEN-1:0] st_wdata,
    output logic [3:0]      st_be,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_addr_lo,
    input  logic [XLEN-1:0] ld_rdata,
    output logic [XLEN-1:0] ld_value
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = 8'(ld_rdata >> {ld_addr_lo, 3'b000});
    assign w_half = 16'(ld_rdata >> {ld_addr_lo[1], 4'b0000});

    always_comb begin
        st_wdata = st_data;
        st_be    = c_BE_WORD;
        case (st_size)
            2'b00: begin
                st_wdata = {(XLEN/8){st_data[7:0]}};
                st_be    = c_BE_BYTE << st_addr_lo;
            end
            2'b01: begin
                st_wdata = {(XLEN/16){st_data[15:0]}};
                st_be    = c_BE_HALF << {st_addr_lo[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (ld_funct3)
            c_F3_B:  ld_value = {{(XLEN-8){w_byte[7]}}, w_byte};
            c_F3_BU: ld_value = {{(XLEN-8){1'b0}}, w_byte};
            c_F3_H:  ld_value = {{(XLEN-16){w_half[15]}}, w_half};
            c_F3_HU: ld_value = {{(XLEN-16){1'b0}}, w_half};
            default: ld_value = ld_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage load/store unit: dmem req/ack handshake with
//               timeout, store alignment, load extension, memwb forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import rv_mem_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic            mem_read_in,
    input  logic            mem_write_in,
    input  logic [2:0]      funct3_in,
    input  logic [XLEN-1:0] addr_in,
    input  logic [XLEN-1:0] store_data_in,
    input  logic [XLEN-1:0] result_in,
    input  logic [XLEN-1:0] sum_out_in,
    input  logic [1:0]      controlRF_in,
    input  logic            we_in,
    input  logic [4:0]      rd_in,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ack,
    output logic            stall_out,
    output logic [XLEN-1:0] loadData_out,
    output logic [XLEN-1:0] result_out,
    output logic [XLEN-1:0] sum_out_out,
    output logic [1:0]      controlRF_out,
    output logic [4:0]      rd_out,
    output logic            we_out,
    output logic            fault_out,
    output logic            bus_err_out
);

    localparam int CNT_W = $clog2(TIMEOUT);

    mau_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic [XLEN-1:0]  r_load;
    logic             r_is_load;
    logic [2:0]       r_funct3;
    logic [1:0]       r_addr_lo;

    logic             w_is_mem;
    logic             w_legal;
    logic             w_start;
    logic             w_fault;
    logic [XLEN-1:0]  w_wdata;
    logic [XLEN-1:0]  w_ld_value;
    logic [3:0]       w_be;

    assign w_is_mem = valid_in & (mem_read_in | mem_write_in);
    assign w_legal  = ~(mem_read_in & mem_write_in) &
                      access_ok(mem_read_in, funct3_in, addr_in[1:0]);
    assign w_start  = (r_state == ST_IDLE) & w_is_mem & w_legal;
    assign w_fault  = (r_state == ST_IDLE) & w_is_mem & ~w_legal;

    // Load extraction works from the captured width/offset, not the live inputs.
    lsu_align #(.XLEN(XLEN)) u_align (
        .st_size    (funct3_in[1:0]),
        .st_addr_lo (addr_in[1:0]),
        .st_data    (store_data_in),
        .st_wdata   (w_wdata),
        .st_be      (w_be),
        .ld_funct3  (r_funct3),
        .ld_addr_lo (r_addr_lo),
        .ld_rdata   (dmem_rdata),
        .ld_value   (w_ld_value)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_load     <= '0;
            r_is_load  <= 1'b0;
            r_funct3   <= '0;
            r_addr_lo  <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_write_in;
                        dmem_addr  <= {addr_in[XLEN-1:2], 2'b00};
                        dmem_wdata <= w_wdata;
                        dmem_be    <= w_be;
                        r_is_load  <= mem_read_in;
                        r_funct3   <= funct3_in;
                        r_addr_lo  <= addr_in[1:0];
                        r_cnt      <= '0;
                        r_err      <= 1'b0;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        r_load   <= r_is_load ? w_ld_value : '0;
                        r_state  <= ST_DONE;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        r_err    <= 1'b1;
                        r_load   <= '0;
                        r_state  <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign result_out    = result_in;
    assign sum_out_out   = sum_out_in;
    assign controlRF_out = controlRF_in;
    assign rd_out        = rd_in;

    // Held low while in reset so memwb never sees a write or stall.
    always_comb begin
        stall_out    = 1'b0;
        fault_out    = 1'b0;
        bus_err_out  = 1'b0;
        we_out       = 1'b0;
        loadData_out = '0;
        if (rst) begin
            case (r_state)
                ST_IDLE: begin
                    stall_out = w_start;
                    fault_out = w_fault;
                    we_out    = valid_in & we_in & ~w_is_mem;
                end
                ST_WAIT: stall_out = 1'b1;
                ST_DONE: begin
                    we_out       = we_in & ~r_err;
                    bus_err_out  = r_err;
                    loadData_out = r_load;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit with a behavioural
//               reference model and randomized load/store traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            valid_in, mem_read_in, mem_write_in, we_in, dmem_ack;
    logic [2:0]      funct3_in;
    logic [XLEN-1:0] addr_in, store_data_in, result_in, sum_out_in, dmem_rdata;
    logic [1:0]      controlRF_in;
    logic [4:0]      rd_in;
    logic            dmem_req, dmem_we, stall_out, we_out, fault_out, bus_err_out;
    logic [XLEN-1:0] dmem_addr, dmem_wdata, loadData_out, result_out, sum_out_out;
    logic [3:0]      dmem_be;
    logic [1:0]      controlRF_out;
    logic [4:0]      rd_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .funct3_in(funct3_in), .addr_in(addr_in),
        .store_data_in(store_data_in), .result_in(result_in), .sum_out_in(sum_out_in),
        .controlRF_in(controlRF_in), .we_in(we_in), .rd_in(rd_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .stall_out(stall_out), .loadData_out(loadData_out),
        .result_out(result_out), .sum_out_out(sum_out_out), .controlRF_out(controlRF_out),
        .rd_out(rd_out), .we_out(we_out), .fault_out(fault_out), .bus_err_out(bus_err_out)
    );

    // ---------------- reference model ----------------
    function automatic bit ref_legal(bit rd, bit wr, logic [2:0] f3, logic [31:0] addr);
        int size;
        if (rd && wr) return 1'b0;
        if (rd && !(int'(f3) inside {0, 1, 2, 4, 5})) return 1'b0;
        if (wr && !(int'(f3) inside {0, 1, 2})) return 1'b0;
        size = 1 << (int'(f3) % 4);
        return (int'(addr % 32'd4) % size) == 0;
    endfunction

    function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] addr, logic [31:0] rdata);
        int     size = 1 << (int'(f3) % 4);
        int     off  = int'(addr % 32'd4);
        longint v;
        v = (longint'(rdata) >> (8 * off)) & ((longint'(1) << (8 * size)) - 1);
        if (f3 < 3'd4 && size < 4 && v >= (longint'(1) << (8 * size - 1)))
            v = v - (longint'(1) << (8 * size));
        return v[31:0];
    endfunction

    function automatic logic [3:0] ref_be(logic [2:0] f3, logic [31:0] addr);
        int size = 1 << (int'(f3) % 4);
        int be   = ((1 << size) - 1) << int'(addr % 32'd4);
        return be[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(logic [2:0] f3, logic [31:0] sdata);
        int          size = 1 << (int'(f3) % 4);
        logic [31:0] w    = '0;
        for (int i = 0; i < 4; i++)
            w = w | (((sdata >> (8 * (i % size))) & 32'hFF) << (8 * i));
        return w;
    endfunction

    task automatic drive_bubble();
        valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0; we_in = 1'b0;
        funct3_in = 3'b000; addr_in = '0; store_data_in = '0;
    endtask

    // ---------------- scenario tasks ----------------
    task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] sdata,
                              input logic [31:0] rdata, input int ack_dly, input bit we);
        int          stalls = 0;
        bit          done   = 1'b0;
        bit          tmo    = (ack_dly < 0);
        int          exp_stalls = tmo ? TIMEOUT + 1 : ack_dly + 2;
        logic [31:0] res, sum;
        logic [31:0] exp_ld;
        res = $urandom; sum = $urandom;
        exp_ld = rd ? ref_load(f3, addr, rdata) : 32'h0;
        @(negedge clk);
        valid_in = 1'b1; mem_read_in = rd; mem_write_in = wr; funct3_in = f3;
        addr_in = addr; store_data_in = sdata; we_in = we; result_in = res;
        sum_out_in = sum; controlRF_in = 2'($urandom_range(0, 3)); rd_in = 5'($urandom_range(0, 31));
        for (int cyc = 0; cyc < TIMEOUT + 6 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            dmem_ack   = (!tmo && cyc == ack_dly + 1);
            dmem_rdata = dmem_ack ? rdata : $urandom;
            #1;
            if (stall_out === 1'b1) begin
                stalls++;
                n_cmp++;
                if (we_out !== 1'b0) begin n_err++; $display("FAIL we_during_stall: got %b want 0 (cyc %0d)", we_out, cyc); end
                n_cmp++;
                if (cyc == 0) begin
                    if (dmem_req !== 1'b0) begin n_err++; $display("FAIL req_early: got %b want 0", dmem_req); end
                end else if (dmem_req !== 1'b1 || dmem_we !== wr || dmem_addr !== {addr[31:2], 2'b00}) begin
                    n_err++;
                    $display("FAIL req_hold: got req=%b we=%b addr=%h want req=1 we=%b addr=%h",
                             dmem_req, dmem_we, dmem_addr, wr, {addr[31:2], 2'b00});
                end
                if (cyc > 0 && wr) begin
                    n_cmp++;
                    if (dmem_be !== ref_be(f3, addr) || dmem_wdata !== ref_wdata(f3, sdata)) begin
                        n_err++;
                        $display("FAIL store_lanes: got be=%b wdata=%h want be=%b wdata=%h",
                                 dmem_be, dmem_wdata, ref_be(f3, addr), ref_wdata(f3, sdata));
                    end
                end
            end else begin
                done = 1'b1;
                n_cmp++;
                if (stalls != exp_stalls) begin n_err++; $display("FAIL stall_count: got %0d want %0d", stalls, exp_stalls); end
                n_cmp++;
                if (dmem_req !== 1'b0 || fault_out !== 1'b0) begin n_err++; $display("FAIL done_req: got req=%b fault=%b want 0 0", dmem_req, fault_out); end
                n_cmp++;
                if (bus_err_out !== tmo) begin n_err++; $display("FAIL bus_err: got %b want %b", bus_err_out, tmo); end
                n_cmp++;
                if (we_out !== (we & !tmo)) begin n_err++; $display("FAIL done_we: got %b want %b", we_out, we & !tmo); end
                n_cmp++;
                if (result_out !== res || sum_out_out !== sum) begin n_err++; $display("FAIL passthru: got %h/%h want %h/%h", result_out, sum_out_out, res, sum); end
                if (!tmo) begin
                    n_cmp++;
                    if (loadData_out !== exp_ld) begin
                        n_err++;
                        $display("FAIL load_data: f3=%b addr=%h got %h want %h", f3, addr, loadData_out, exp_ld);
                    end
                end
            end
        end
        if (!done) begin n_err++; $display("FAIL access_bound: stall never released after %0d cycles", stalls); end
        dmem_ack = 1'b0;
    endtask

    task automatic run_fault(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr);
        @(negedge clk);
        valid_in = 1'b1; mem_read_in = rd; mem_write_in = wr; funct3_in = f3;
        addr_in = addr; store_data_in = $urandom; we_in = 1'b1;
        #1;
        n_cmp++;
        if (fault_out !== 1'b1 || stall_out !== 1'b0 || we_out !== 1'b0) begin
            n_err++;
            $display("FAIL fault_cycle: f3=%b addr=%h got fault=%b stall=%b we=%b want 1 0 0",
                     f3, addr, fault_out, stall_out, we_out);
        end
        @(negedge clk);
        drive_bubble();
        #1;
        n_cmp++;
        if (fault_out !== 1'b0 || dmem_req !== 1'b0) begin
            n_err++;
            $display("FAIL fault_after: got fault=%b req=%b want 0 0", fault_out, dmem_req);
        end
    endtask

    task automatic run_nonmem();
        bit          we = 1'($urandom_range(0, 1));
        logic [31:0] res;
        res = $urandom;
        @(negedge clk);
        valid_in = 1'b1; mem_read_in = 1'b0; mem_write_in = 1'b0; we_in = we;
        funct3_in = 3'($urandom_range(0, 7)); addr_in = $urandom; result_in = res;
        rd_in = 5'($urandom_range(0, 31));
        #1;
        n_cmp++;
        if (we_out !== we || stall_out !== 1'b0 || fault_out !== 1'b0 || result_out !== res || rd_out !== rd_in) begin
            n_err++;
            $display("FAIL nonmem: got we=%b stall=%b fault=%b res=%h want we=%b stall=0 fault=0 res=%h",
                     we_out, stall_out, fault_out, result_out, we, res);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        valid_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0; funct3_in = 3'b010;
        addr_in = 32'h100; store_data_in = '0; we_in = 1'b1; result_in = '0;
        sum_out_in = '0; controlRF_in = '0; rd_in = '0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || stall_out !== 1'b0 || fault_out !== 1'b0 ||
            bus_err_out !== 1'b0 || we_out !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got req=%b we=%b stall=%b fault=%b berr=%b we_out=%b want all 0",
                     dmem_req, dmem_we, stall_out, fault_out, bus_err_out, we_out);
        end
        @(negedge clk);
        drive_bubble();
        dmem_ack = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_spec_vectors();
        run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b1);
        run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0, 1'b1);
        run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 1, 1'b1);
        run_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 0, 1'b0);
        run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_7FFF, 2, 1'b1);
        run_access(1'b0, 1'b1, 3'b000, 32'h101, 32'h0000_00A5, 32'h0, 3, 1'b0);
    endtask

    task automatic test_misaligned();
        run_fault(1'b1, 1'b0, 3'b010, 32'h101);
        run_fault(1'b1, 1'b0, 3'b101, 32'h103);
        run_fault(1'b0, 1'b1, 3'b010, 32'h102);
        run_fault(1'b1, 1'b0, 3'b011, 32'h100);
        run_fault(1'b0, 1'b1, 3'b100, 32'h100);
        run_fault(1'b1, 1'b1, 3'b010, 32'h100);
    endtask

    task automatic test_timeout();
        run_access(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h0, -1, 1'b1);
        @(negedge clk);
        drive_bubble();
        #1;
        n_cmp++;
        if (bus_err_out !== 1'b0 || stall_out !== 1'b0 || dmem_req !== 1'b0) begin
            n_err++;
            $display("FAIL bus_err_pulse: got berr=%b stall=%b req=%b want 0 0 0", bus_err_out, stall_out, dmem_req);
        end
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        valid_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0; funct3_in = 3'b010;
        addr_in = 32'h300; we_in = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive_bubble();
        #1;
        n_cmp++;
        if (dmem_req !== 1'b0 || stall_out !== 1'b0 || we_out !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got req=%b stall=%b we=%b want 0 0 0", dmem_req, stall_out, we_out);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (dmem_req !== 1'b0 || stall_out !== 1'b0 || we_out !== 1'b0 || bus_err_out !== 1'b0) begin
                n_err++;
                $display("FAIL late_ack: got req=%b stall=%b we=%b berr=%b want 0 0 0 0",
                         dmem_req, stall_out, we_out, bus_err_out);
            end
            @(negedge clk);
            dmem_ack = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            run_access(1'b1, 1'b0, 3'b000, 32'h400 + 32'(i), 32'h0, 32'h8844_2211, 0, 1'b1);
        run_nonmem();
        run_access(1'b0, 1'b1, 3'b010, 32'h500, 32'hCAFE_F00D, 32'h0, 0, 1'b0);
    endtask

    task automatic test_random();
        int          kind;
        bit          rd, wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [2:0]  ld_codes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            if (kind < 2) begin
                run_nonmem();
            end else begin
                if (kind == 2) begin
                    rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
                    if (!rd && !wr) rd = 1'b1;
                    f3 = 3'($urandom_range(0, 7));
                    addr = $urandom;
                end else begin
                    rd = 1'($urandom_range(0, 1)); wr = !rd;
                    f3 = rd ? ld_codes[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
                    addr = $urandom;
                    addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
                end
                if (ref_legal(rd, wr, f3, addr))
                    run_access(rd, wr, f3, addr, $urandom, $urandom, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
                else
                    run_fault(rd, wr, f3, addr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_misaligned();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        test_random();
        @(negedge clk);
        drive_bubble();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
